// File: rtl/pps_generator_pkg.sv
// Shared FSM encodings and register-map constants for the PPS generator
// and its PPS-path neighbours.
package pps_generator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACQUIRE  = 3'd1,
        ST_TRACK    = 3'd2,
        ST_LOCKED   = 3'd3,
        ST_HOLDOVER = 3'd4
    } pps_state_e;

    localparam int unsigned DATA_WIDTH = 32;

    // Zero-extends the FSM state into a register-map word.
    function automatic logic [DATA_WIDTH-1:0] state_reg_word(input pps_state_e st);
        return {{(DATA_WIDTH-3){1'b0}}, st};
    endfunction

endpackage

// File: rtl/pps_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous PPS
// input; i_clr flushes the pipeline so a stale level cannot fake an edge.
module pps_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_async,
    output logic o_edge
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    // Next-state of the synchronizer and edge-history flops.
    always_comb begin
        if (i_clr) begin
            s1_d = 1'b0;
            s2_d = 1'b0;
            s3_d = 1'b0;
        end else begin
            s1_d = i_async;
            s2_d = s1_q;
            s3_d = s2_q;
        end
    end

    // Synchronizer and edge-history registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign o_edge = s2_q & ~s3_q;

endmodule

// File: rtl/pps_generator.sv
// Local 1 PPS generator: aligns a free-running second counter to a reference
// PPS, tracks it within a tolerance window and flywheels through dropouts.
module pps_generator
    import pps_generator_pkg::*;
#(
    parameter int unsigned CLKS_PER_SEC     = 10000000,
    parameter int unsigned PULSE_WIDTH_CLKS = 1000000,
    parameter int unsigned LOCK_COUNT       = 3,
    parameter int unsigned MAX_ERR_CLKS     = 2,
    parameter int unsigned MISS_TOL_CLKS    = 20,
    parameter int unsigned CNT_W            = 24,
    parameter int unsigned ERR_W            = CNT_W + 1
) (
    input  logic                    i_clk_10,
    input  logic                    i_rst,
    input  logic                    i_enable,
    input  logic                    i_pps_ref,
    output logic                    o_pps,
    output logic                    o_sec_tick,
    output logic                    o_locked,
    output logic                    o_holdover,
    output logic signed [ERR_W-1:0] o_phase_err,
    output logic [2:0]              o_state
);

    localparam int unsigned GOOD_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CLKS_PER_SEC - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLKS_PER_SEC / 2);
    localparam logic [CNT_W-1:0]  WIN_OPEN  = CNT_W'(CLKS_PER_SEC - MISS_TOL_CLKS);
    localparam logic [CNT_W-1:0]  WIN_CLOSE = CNT_W'(MISS_TOL_CLKS);
    localparam logic [CNT_W-1:0]  PULSE_END = CNT_W'(PULSE_WIDTH_CLKS);
    localparam logic [GOOD_W-1:0] LOCK_V    = GOOD_W'(LOCK_COUNT);

    pps_state_e               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [GOOD_W-1:0]        good_q, good_d;
    logic                     win_q, win_d;
    logic signed [ERR_W-1:0]  err_q, err_d;

    logic                     ref_edge_s, edge_s, in_win_s, in_tol_s, miss_s;
    logic [ERR_W-1:0]         cnt_ext_s, err_mag_s;
    logic signed [ERR_W-1:0]  err_s;
    logic [GOOD_W-1:0]        good_inc_s;

    pps_sync_edge u_sync (
        .i_clk   (i_clk_10),
        .i_rst   (i_rst),
        .i_clr   (state_q == ST_IDLE),
        .i_async (i_pps_ref),
        .o_edge  (ref_edge_s)
    );

    // Error is measured against the wrap point: late edges positive, early negative.
    assign cnt_ext_s  = ERR_W'(cnt_q);
    assign err_s      = (cnt_q >= CNT_HALF) ? $signed(cnt_ext_s - ERR_W'(CLKS_PER_SEC - 1))
                                            : $signed(cnt_ext_s + ERR_W'(1));
    assign err_mag_s  = err_s[ERR_W-1] ? $unsigned(-err_s) : $unsigned(err_s);
    assign edge_s     = ref_edge_s && (state_q != ST_IDLE);
    assign in_win_s   = win_q || (cnt_q == WIN_OPEN);
    assign in_tol_s   = in_win_s && (err_mag_s <= ERR_W'(MAX_ERR_CLKS));
    assign miss_s     = win_q && (cnt_q == WIN_CLOSE) && !edge_s;
    assign good_inc_s = good_q + GOOD_W'(1);

    // Next-state, counter, window and lock-qualification logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        good_d  = good_q;
        win_d   = win_q;
        err_d   = edge_s ? err_s : err_q;
        if (!i_enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            good_d  = '0;
            win_d   = 1'b0;
        end else begin
            if (edge_s) begin
                win_d = 1'b0;
                cnt_d = '0;
            end else if (cnt_q == WIN_OPEN) begin
                win_d = 1'b1;
            end else if (cnt_q == WIN_CLOSE) begin
                win_d = 1'b0;
            end else begin
                win_d = win_q;
            end
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQUIRE;
                    cnt_d   = '0;
                    good_d  = '0;
                    win_d   = 1'b0;
                end
                ST_ACQUIRE: begin
                    if (edge_s) begin
                        good_d  = GOOD_W'(1);
                        state_d = ST_TRACK;
                    end else begin
                        state_d = ST_ACQUIRE;
                    end
                end
                ST_TRACK: begin
                    if (edge_s && in_tol_s) begin
                        good_d  = good_inc_s;
                        state_d = (good_inc_s >= LOCK_V) ? ST_LOCKED : ST_TRACK;
                    end else if (edge_s) begin
                        good_d  = GOOD_W'(1);
                    end else if (miss_s) begin
                        good_d  = '0;
                        state_d = ST_ACQUIRE;
                    end else begin
                        state_d = ST_TRACK;
                    end
                end
                ST_LOCKED: begin
                    if (edge_s && !in_tol_s) begin
                        good_d  = GOOD_W'(1);
                        state_d = ST_TRACK;
                    end else if (miss_s) begin
                        state_d = ST_HOLDOVER;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
                ST_HOLDOVER: begin
                    if (edge_s && in_tol_s) begin
                        state_d = ST_LOCKED;
                    end else if (edge_s) begin
                        good_d  = GOOD_W'(1);
                        state_d = ST_TRACK;
                    end else begin
                        state_d = ST_HOLDOVER;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and phase-error registers.
    always_ff @(posedge i_clk_10) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            good_q  <= '0;
            win_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            good_q  <= good_d;
            win_q   <= win_d;
            err_q   <= err_d;
        end
    end

    assign o_pps       = (state_q != ST_IDLE) && (cnt_q < PULSE_END);
    assign o_sec_tick  = (state_q != ST_IDLE) && (cnt_q == '0);
    assign o_locked    = (state_q == ST_LOCKED);
    assign o_holdover  = (state_q == ST_HOLDOVER);
    assign o_phase_err = err_q;
    assign o_state     = state_q;

endmodule
